instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: ADDR_W, 16, instruction word-address width.
REQ-002 Parameter: RESET_PC, 0, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: mem_req  output  1  instruction-memory read request.
REQ-006 Port: mem_addr  output  ADDR_W  word address of the request.
REQ-007 Port: mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-008 Port: mem_rdata  input  64  instruction word from memory.
REQ-009 Port: jump  input  1  redirect fetch to jump_target.
REQ-010 Port: jump_target  input  ADDR_W  redirect address.
REQ-011 Port: stall  input  1  downstream instruction register not accepting.
REQ-012 Port: instr  output  64  fetched instruction; feeds the instruction register's 64-bit input.
REQ-013 Port: instr_valid  output  1  instr holds a valid, not-yet-consumed instruction.
REQ-014 Port: instr_pc  output  ADDR_W  address instr was fetched from.

Function
REQ-015 SHALL implement a two-state FSM: FETCH (mem_req=1) and HOLD (instr_valid=1); outputs decoded from registered state only.
REQ-016 FETCH: mem_addr = fetch_pc; mem_addr and mem_req SHALL stay stable until the cycle mem_ack=1.
REQ-017 FETCH with mem_ack=1, no redirect pending, jump=0: capture mem_rdata into instr, instr_pc <= fetch_pc, fetch_pc <= fetch_pc+1, go HOLD.
REQ-018 HOLD: consumption = instr_valid & !stall at a clock edge; on consumption go FETCH; while stall=1 hold instr, instr_pc, fetch_pc unchanged.
REQ-019 fetch_pc+1 SHALL wrap modulo 2^ADDR_W (max address -> 0).
REQ-020 jump=1 in HOLD: fetch_pc <= jump_target, go FETCH, held instruction discarded regardless of stall.
REQ-021 jump=1 in FETCH with mem_ack=1: discard mem_rdata, fetch_pc <= jump_target, stay FETCH.
REQ-022 jump=1 in FETCH with mem_ack=0: fetch_pc unchanged (address stability), store jump_target in redirect_pc, set redirect_pending.
REQ-023 FETCH with mem_ack=1 and redirect_pending=1: discard mem_rdata, fetch_pc <= redirect_pc, clear redirect_pending, stay FETCH.
REQ-024 A newer jump SHALL overwrite redirect_pc; jump in the same cycle as REQ-023 takes precedence (fetch_pc <= jump_target).
REQ-025 mem_ack outside FETCH SHALL be ignored.
REQ-026 Throughput: with zero-wait memory and no stall, one instruction every 2 cycles.

Reset
REQ-027 rst=1 at an edge: state <= FETCH, fetch_pc <= RESET_PC, redirect_pending <= 0, instr <= 0, instr_pc <= 0; overrides jump/mem_ack same cycle.
REQ-028 Output values in the first cycle after reset: mem_req=1, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-029 Reset mid-transaction SHALL abandon any outstanding request; an ack arriving after reset is treated as acknowledging the new RESET_PC request.

Structure
REQ-030 FSM state encoding and ADDR_W default SHALL live in a shared cpu_pkg package for reuse by the decoder.
REQ-031 Single module; no sub-module; instruction register remains a separate downstream instance.

Verification
REQ-032 Reset release, mem_ack=1 every FETCH cycle, rdata=addr+0x100, stall=0 -> instr_pc sequence 0,1,2,3 with instr_valid every second cycle.
REQ-033 stall=1 for 5 cycles while instr_valid=1 at pc 4 -> instr, instr_pc=4 held, mem_req=0 throughout; fetch of 5 follows stall release.
REQ-034 jump=1, target 0x40, during FETCH with mem_ack=0, ack 3 cycles later -> mem_addr unchanged until ack, data discarded, next request addr 0x40.
REQ-035 jump=1, target 0x10, in HOLD with stall=1 -> instr_valid=0 next cycle, mem_addr=0x10.
REQ-036 fetch_pc=0xFFFF, ack -> instr_pc=0xFFFF, next mem_addr=0x0000.
REQ-037 rst=1 asserted with redirect_pending set -> next cycle mem_addr=RESET_PC, redirect ignored after ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and default address width.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: one request per FETCH, instruction held in HOLD until consumed; 2 cycles/instr at zero wait.
// Backpressure: stall freezes HOLD; jumps arriving mid-request are deferred so mem_addr stays stable until mem_ack.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              stall,
  output logic [63:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] redirect_pc, redirect_pc_n;
  logic              redirect_pending, redirect_pending_n;
  logic [63:0]       instr_q, instr_n;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FETCH;
      fetch_pc         <= RESET_PC;
      redirect_pc      <= '0;
      redirect_pending <= 1'b0;
      instr_q          <= '0;
      instr_pc_q       <= '0;
    end else begin
      state            <= state_n;
      fetch_pc         <= fetch_pc_n;
      redirect_pc      <= redirect_pc_n;
      redirect_pending <= redirect_pending_n;
      instr_q          <= instr_n;
      instr_pc_q       <= instr_pc_n;
    end
  end

  always_comb begin
    state_n            = state;
    fetch_pc_n         = fetch_pc;
    redirect_pc_n      = redirect_pc;
    redirect_pending_n = redirect_pending;
    instr_n            = instr_q;
    instr_pc_n         = instr_pc_q;

    unique case (state)
      FETCH: begin
        if (mem_ack) begin
          // A same-cycle jump beats a deferred redirect; either way the returned word is stale.
          if (jump) begin
            fetch_pc_n         = jump_target;
            redirect_pending_n = 1'b0;
          end else if (redirect_pending) begin
            fetch_pc_n         = redirect_pc;
            redirect_pending_n = 1'b0;
          end else begin
            instr_n    = mem_rdata;
            instr_pc_n = fetch_pc;
            fetch_pc_n = fetch_pc + ADDR_W'(1);
            state_n    = HOLD;
          end
        end else if (jump) begin
          redirect_pc_n      = jump_target;
          redirect_pending_n = 1'b1;
        end
      end
      HOLD: begin
        if (jump) begin
          fetch_pc_n = jump_target;
          state_n    = FETCH;
        end else if (!stall) begin
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  assign mem_req     = (state == FETCH);
  assign mem_addr    = fetch_pc;
  assign instr_valid = (state == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: transaction-level model, directed scenarios, then random traffic.
module tb_instruction_fetch;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [63:0]       mem_rdata;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              stall;
  logic [63:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;

  instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .jump(jump), .jump_target(jump_target),
    .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the address currently being requested, an optional delivered instruction,
  // and an optional deferred redirect address.
  logic [ADDR_W-1:0] m_addr;
  logic              m_have;
  logic [63:0]       m_instr;
  logic [ADDR_W-1:0] m_ipc;
  logic              m_redir;
  logic [ADDR_W-1:0] m_redir_addr;

  task automatic model_step();
    if (rst) begin
      m_addr  = 16'h0000;
      m_have  = 1'b0;
      m_instr = 64'd0;
      m_ipc   = 16'h0000;
      m_redir = 1'b0;
    end else if (m_have) begin
      if (jump) begin
        m_have = 1'b0;
        m_addr = jump_target;
      end else if (!stall) begin
        m_have = 1'b0;
      end
    end else if (mem_ack) begin
      if (jump) begin
        m_addr  = jump_target;
        m_redir = 1'b0;
      end else if (m_redir) begin
        m_addr  = m_redir_addr;
        m_redir = 1'b0;
      end else begin
        m_instr = mem_rdata;
        m_ipc   = m_addr;
        m_addr  = 16'((32'(m_addr) + 1) % 65536);
        m_have  = 1'b1;
      end
    end else if (jump) begin
      m_redir      = 1'b1;
      m_redir_addr = jump_target;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("mem_req", 64'(mem_req), 64'(!m_have));
    if (!m_have) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("instr_valid", 64'(instr_valid), 64'(m_have));
    chk("instr", instr, m_instr);
    chk("instr_pc", 64'(instr_pc), 64'(m_ipc));
  endtask

  // Inputs are applied at the falling edge; the model advances at the rising edge,
  // and the DUT is compared at the next falling edge.
  task automatic drv(input logic r, input logic a, input logic j,
                     input logic [ADDR_W-1:0] t, input logic s);
    rst         = r;
    mem_ack     = a;
    jump        = j;
    jump_target = t;
    stall       = s;
    mem_rdata   = 64'(m_addr) + 64'h100;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    m_addr = '0; m_have = 0; m_instr = '0; m_ipc = '0; m_redir = 0; m_redir_addr = '0;
    drv(1, 1, 1, 16'h1234, 0);
    tick();
    tick();
    chk("rst mem_req", 64'(mem_req), 64'd1);
    chk("rst mem_addr", 64'(mem_addr), 64'h0);
    chk("rst instr_valid", 64'(instr_valid), 64'd0);
    chk("rst instr", instr, 64'd0);
    chk("rst instr_pc", 64'(instr_pc), 64'd0);

    // Zero-wait streaming: a new instruction every second cycle.
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, 0, 16'h0, 0);
      tick();
      chk("stream valid", 64'(instr_valid), 64'(i % 2 == 0));
      if (i % 2 == 0) chk("stream pc", 64'(instr_pc), 64'(i / 2));
    end

    // Stall with pc 4 held.
    drv(0, 1, 0, 16'h0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 0, 16'h0, 1);
      tick();
      chk("stall pc", 64'(instr_pc), 64'h4);
      chk("stall instr", instr, 64'h104);
      chk("stall mem_req", 64'(mem_req), 64'd0);
    end
    drv(0, 1, 0, 16'h0, 0);
    tick();
    chk("post-stall mem_req", 64'(mem_req), 64'd1);
    chk("post-stall addr", 64'(mem_addr), 64'h5);

    // Jump while a request is outstanding is deferred until the ack.
    drv(0, 0, 1, 16'h40, 0);
    tick();
    chk("deferred addr0", 64'(mem_addr), 64'h5);
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 0, 16'h0, 0);
      tick();
      chk("deferred addr", 64'(mem_addr), 64'h5);
    end
    drv(0, 1, 0, 16'h0, 0);
    tick();
    chk("redirect valid", 64'(instr_valid), 64'd0);
    chk("redirect addr", 64'(mem_addr), 64'h40);

    // Jump in HOLD under stall discards the instruction.
    drv(0, 1, 0, 16'h0, 0);
    tick();
    chk("hold pc 0x40", 64'(instr_pc), 64'h40);
    drv(0, 0, 1, 16'h10, 1);
    tick();
    chk("hold-jump valid", 64'(instr_valid), 64'd0);
    chk("hold-jump addr", 64'(mem_addr), 64'h10);

    // Address wrap at the top of the space.
    drv(0, 1, 1, 16'hFFFF, 0);
    tick();
    chk("jump-ack addr", 64'(mem_addr), 64'hFFFF);
    drv(0, 1, 0, 16'h0, 0);
    tick();
    chk("wrap instr_pc", 64'(instr_pc), 64'hFFFF);
    drv(0, 0, 0, 16'h0, 0);
    tick();
    chk("wrap mem_addr", 64'(mem_addr), 64'h0);

    // Reset clears a pending redirect.
    drv(0, 0, 1, 16'h77, 0);
    tick();
    drv(1, 1, 0, 16'h0, 0);
    tick();
    chk("rst-redir addr", 64'(mem_addr), 64'h0);
    chk("rst-redir req", 64'(mem_req), 64'd1);
    drv(0, 1, 0, 16'h0, 0);
    tick();
    chk("rst-redir valid", 64'(instr_valid), 64'd1);
    chk("rst-redir pc", 64'(instr_pc), 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom),
          ($urandom_range(0, 2) == 0));
      mem_rdata = {$urandom, $urandom};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
